clk_pattern_gen: RTL

//   Synthesizable programmable clock-pattern generator driven from the 100 MHz system clock.

---
 rtl/clk_pattern_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_pattern_gen.sv
// -----------------------------------------------------------------------------
// clk_pattern_gen
//   Programmable clock-pattern generator running from the system clock.
//   clk_out is a registered waveform: an optional phase delay after start, then
//   repeating periods of ton high cycles followed by toff low cycles.
//   A new configuration is taken over a valid/ready port into a pending slot and
//   only becomes active at a period boundary, so clk_out never glitches.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          run request (level); a stop takes effect only at a period end
//   cfg_valid   config offered this cycle
//   cfg_ready   pending slot empty, config can be accepted
//   cfg_phase   cycles from start to first rising edge of clk_out
//   cfg_ton     high cycles per period (>= 1)
//   cfg_toff    low cycles per period (>= 1)
//   cfg_err     one-cycle pulse when an accepted offer had ton or toff of zero
//   clk_out     generated waveform (registered)
//   rise_pulse  one-cycle pulse on the first high cycle of each period
//   busy        generator not idle
// -----------------------------------------------------------------------------
module clk_pattern_gen #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_toff,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PHASE = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             r_act_v;
    logic [CNT_W-1:0] r_act_ph;
    logic [CNT_W-1:0] r_act_ton;
    logic [CNT_W-1:0] r_act_toff;

    logic             r_pend_v;
    logic [CNT_W-1:0] r_pend_ph;
    logic [CNT_W-1:0] r_pend_ton;
    logic [CNT_W-1:0] r_pend_toff;

    logic             r_clk_out;
    logic             r_rise;
    logic             r_err;

    logic [1:0]       w_state_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_apply;
    logic             w_accept;
    logic             w_cfg_bad;
    logic             w_cnt_last;
    logic [CNT_W-1:0] w_eff_ph;
    logic [CNT_W-1:0] w_eff_ton;

    assign w_accept   = cfg_valid && !r_pend_v;
    assign w_cfg_bad  = (cfg_ton == CNT_ZERO) || (cfg_toff == CNT_ZERO);
    assign w_cnt_last = (r_cnt == CNT_ONE);

    // Every counter load point is also a pending-apply point, so the load value
    // comes from the pending slot whenever it is occupied.
    assign w_eff_ph  = r_pend_v ? r_pend_ph  : r_act_ph;
    assign w_eff_ton = r_pend_v ? r_pend_ton : r_act_ton;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_apply   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_apply = r_pend_v;
                if (en && r_act_v) begin
                    if (w_eff_ph == CNT_ZERO) begin
                        w_state_d = S_HIGH;
                        w_cnt_d   = w_eff_ton;
                    end else begin
                        w_state_d = S_PHASE;
                        w_cnt_d   = w_eff_ph;
                    end
                end
            end
            S_PHASE: begin
                if (!en) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = CNT_ZERO;
                end else if (w_cnt_last) begin
                    w_apply   = r_pend_v;
                    w_state_d = S_HIGH;
                    w_cnt_d   = w_eff_ton;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            S_HIGH: begin
                // Active config cannot change inside a period, so toff is stable.
                if (w_cnt_last) begin
                    w_state_d = S_LOW;
                    w_cnt_d   = r_act_toff;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            S_LOW: begin
                if (w_cnt_last) begin
                    w_apply = r_pend_v;
                    if (en) begin
                        w_state_d = S_HIGH;
                        w_cnt_d   = w_eff_ton;
                    end else begin
                        w_state_d = S_IDLE;
                        w_cnt_d   = CNT_ZERO;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Apply and accept are exclusive: accept needs an empty pending slot,
    // apply needs an occupied one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_v     <= 1'b0;
            r_act_ph    <= CNT_ZERO;
            r_act_ton   <= CNT_ZERO;
            r_act_toff  <= CNT_ZERO;
            r_pend_v    <= 1'b0;
            r_pend_ph   <= CNT_ZERO;
            r_pend_ton  <= CNT_ZERO;
            r_pend_toff <= CNT_ZERO;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && w_cfg_bad;
            if (w_apply) begin
                r_act_v    <= 1'b1;
                r_act_ph   <= r_pend_ph;
                r_act_ton  <= r_pend_ton;
                r_act_toff <= r_pend_toff;
                r_pend_v   <= 1'b0;
            end else if (w_accept && !w_cfg_bad) begin
                r_pend_v    <= 1'b1;
                r_pend_ph   <= cfg_phase;
                r_pend_ton  <= cfg_ton;
                r_pend_toff <= cfg_toff;
            end
        end
    end

    // clk_out follows the HIGH state one cycle later; the cycle before a high
    // phase is always low (PHASE, LOW or IDLE), so a low r_clk_out marks the
    // first high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_clk_out <= (r_state == S_HIGH);
            r_rise    <= (r_state == S_HIGH) && !r_clk_out;
        end
    end

    assign cfg_ready  = !r_pend_v;
    assign cfg_err    = r_err;
    assign clk_out    = r_clk_out;
    assign rise_pulse = r_rise;
    assign busy       = (r_state != S_IDLE);

endmodule
